// File: rtl/collect_data_5.sv
// NoC sink stage: captures packets delivered by the five routers into a FIFO
// and lets an operator step through them on seven-segment displays.
module collect_data_5 #(
  parameter int unsigned N2    = 7,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N2-1:0] in_router1,
  input  logic [N2-1:0] in_router2,
  input  logic [N2-1:0] in_router3,
  input  logic [N2-1:0] in_router4,
  input  logic [N2-1:0] in_router5,
  input  logic          key_next,
  input  logic          sw_clear,
  output logic [6:0]    hex_data,
  output logic [6:0]    hex_router,
  output logic [6:0]    hex_count,
  output logic          led_empty,
  output logic          led_drop
);

  localparam int unsigned NR = 5;
  localparam int unsigned PW = N2 - 1;
  localparam int unsigned EW = 3 + PW;
  localparam int unsigned CW = AW + 1;
  localparam logic [6:0] BLANK = 7'b1111111;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'b1111110;
      4'h1: p = 7'b0110000;
      4'h2: p = 7'b1101101;
      4'h3: p = 7'b1111001;
      4'h4: p = 7'b0110011;
      4'h5: p = 7'b1011011;
      4'h6: p = 7'b1011111;
      4'h7: p = 7'b1110000;
      4'h8: p = 7'b1111111;
      4'h9: p = 7'b1111011;
      4'hA: p = 7'b1110111;
      4'hB: p = 7'b0011111;
      4'hC: p = 7'b1001110;
      4'hD: p = 7'b0111101;
      4'hE: p = 7'b1001111;
      default: p = 7'b1000111;
    endcase
    return ~p;
  endfunction

  function automatic logic [6:0] rtr7(input logic [2:0] r);
    logic [6:0] s;
    case (r)
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5: s = seg7({1'b0, r});
      default: s = BLANK;
    endcase
    return s;
  endfunction

  logic [N2-1:0] bus  [NR];
  logic [N2-1:0] prev [NR];
  logic [PW-1:0] pdata [NR];
  logic [NR-1:0] pend;
  logic [NR-1:0] evt;
  logic [NR-1:0] grant;
  logic [NR-1:0] drop_hit;
  logic          push;
  logic [EW-1:0] push_data;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop;
  logic          key_q;
  logic [3:0]    drop_cnt;
  logic [4:0]    drop_sum;
  logic [EW-1:0] disp;
  logic          disp_valid;
  logic          unused_bits;

  assign bus[0] = in_router1;
  assign bus[1] = in_router2;
  assign bus[2] = in_router3;
  assign bus[3] = in_router4;
  assign bus[4] = in_router5;

  assign full        = (count == CW'(DEPTH));
  assign pop         = key_next && !key_q && (count != '0);
  assign unused_bits = ^disp[PW-1:4];

  // New-packet detection, fixed-priority drain grant and overflow hits
  always_comb begin
    evt       = '0;
    grant     = '0;
    drop_hit  = '0;
    push      = 1'b0;
    push_data = '0;
    for (int i = 0; i < NR; i++) begin
      evt[i] = !sw_clear && bus[i][N2-1] &&
               (!prev[i][N2-1] || (bus[i] != prev[i]));
    end
    if (!full && !sw_clear) begin
      for (int i = 0; i < NR; i++) begin
        if (pend[i] && !push) begin
          grant[i]  = 1'b1;
          push      = 1'b1;
          push_data = {3'(i + 1), pdata[i]};
        end
      end
    end
    for (int i = 0; i < NR; i++) begin
      drop_hit[i] = evt[i] && pend[i] && !grant[i];
    end
    drop_sum = {1'b0, drop_cnt} + 5'($countones(drop_hit));
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        prev[i]  <= '0;
        pdata[i] <= '0;
      end
      pend       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      key_q      <= 1'b0;
      drop_cnt   <= '0;
      disp       <= '0;
      disp_valid <= 1'b0;
    end else begin
      // Input history keeps tracking through a clear so held packets stay old
      for (int i = 0; i < NR; i++) prev[i] <= bus[i];
      if (sw_clear) begin
        pend       <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        key_q      <= 1'b0;
        drop_cnt   <= '0;
        disp_valid <= 1'b0;
      end else begin
        key_q <= key_next;
        for (int i = 0; i < NR; i++) begin
          if (evt[i]) begin
            pend[i]  <= 1'b1;
            pdata[i] <= bus[i][PW-1:0];
          end else if (grant[i]) begin
            pend[i] <= 1'b0;
          end
        end
        drop_cnt <= (drop_sum > 5'd15) ? 4'hF : drop_sum[3:0];
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          disp       <= mem[rd_ptr];
          disp_valid <= 1'b1;
          rd_ptr     <= rd_ptr + AW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Display/LED output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      hex_data   <= BLANK;
      hex_router <= BLANK;
      hex_count  <= seg7(4'h0);
      led_empty  <= 1'b1;
      led_drop   <= 1'b0;
    end else begin
      hex_data   <= disp_valid ? seg7(disp[3:0]) : BLANK;
      hex_router <= disp_valid ? rtr7(disp[EW-1 -: 3]) : BLANK;
      hex_count  <= seg7(4'(count));
      led_empty  <= (count == '0);
      led_drop   <= (drop_cnt != 4'd0);
    end
  end

endmodule

// File: tb/tb_collect_data_5.sv
// Directed bench for collect_data_5: capture, FIFO ordering, drops, pops and clear.
module tb_collect_data_5;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] in_router1, in_router2, in_router3, in_router4, in_router5;
  logic       key_next, sw_clear;
  logic [6:0] hex_data, hex_router, hex_count;
  logic       led_empty, led_drop;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] SEG [16] = '{
    ~7'b1111110, ~7'b0110000, ~7'b1101101, ~7'b1111001,
    ~7'b0110011, ~7'b1011011, ~7'b1011111, ~7'b1110000,
    ~7'b1111111, ~7'b1111011, ~7'b1110111, ~7'b0011111,
    ~7'b1001110, ~7'b0111101, ~7'b1001111, ~7'b1000111};

  collect_data_5 dut (
    .clk(clk), .rst(rst),
    .in_router1(in_router1), .in_router2(in_router2), .in_router3(in_router3),
    .in_router4(in_router4), .in_router5(in_router5),
    .key_next(key_next), .sw_clear(sw_clear),
    .hex_data(hex_data), .hex_router(hex_router), .hex_count(hex_count),
    .led_empty(led_empty), .led_drop(led_drop));

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, got, exp);
  endtask

  task automatic do_pop();
    key_next = 1'b1;
    tick();
    key_next = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; key_next = 1'b0; sw_clear = 1'b0;
    in_router1 = '0; in_router2 = '0; in_router3 = '0; in_router4 = '0; in_router5 = '0;
    tick(2);
    chk("rst_hex_data", hex_data, BLANK);
    chk("rst_hex_router", hex_router, BLANK);
    chk("rst_hex_count", hex_count, SEG[0]);
    chk("rst_led_empty", {6'd0, led_empty}, 7'd1);
    chk("rst_led_drop", {6'd0, led_drop}, 7'd0);
    rst = 1'b0;
    tick();

    // single capture from router3, payload 5
    in_router3 = 7'b1_000101;
    tick(3);
    chk("t1_count1", hex_count, SEG[1]);
    chk("t1_not_empty", {6'd0, led_empty}, 7'd0);
    do_pop();
    chk("t1_router", hex_router, SEG[3]);
    chk("t1_data", hex_data, SEG[5]);
    chk("t1_count0", hex_count, SEG[0]);
    chk("t1_empty", {6'd0, led_empty}, 7'd1);
    in_router3 = '0;
    tick();

    // all five routers at once; drained one per cycle in priority order
    in_router1 = 7'b1_000001; in_router2 = 7'b1_000010; in_router3 = 7'b1_000011;
    in_router4 = 7'b1_000100; in_router5 = 7'b1_000101;
    tick(2);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t2_fill%0d", i), hex_count, SEG[i]);
      tick();
    end
    in_router1 = '0; in_router2 = '0; in_router3 = '0; in_router4 = '0; in_router5 = '0;
    for (int k = 1; k <= 5; k++) begin
      do_pop();
      chk($sformatf("t2_router%0d", k), hex_router, SEG[k]);
      chk($sformatf("t2_data%0d", k), hex_data, SEG[k]);
    end
    chk("t2_count0", hex_count, SEG[0]);

    // held valid input captured once; payload change captured again
    in_router2 = 7'b1_000110;
    tick(100);
    chk("t3_once", hex_count, SEG[1]);
    in_router2 = 7'b1_001001;
    tick(3);
    chk("t3_change", hex_count, SEG[2]);
    do_pop();
    chk("t3_data6", hex_data, SEG[6]);
    do_pop();
    chk("t3_data9", hex_data, SEG[9]);
    chk("t3_router2", hex_router, SEG[2]);
    in_router2 = '0;
    tick();

    // fill to eight from router5, then overflow on router4
    for (int v = 1; v <= 8; v++) begin
      in_router5 = {1'b1, 6'(v)};
      tick();
    end
    in_router5 = '0;
    tick(3);
    chk("t4_full", hex_count, SEG[8]);
    chk("t4_no_drop", {6'd0, led_drop}, 7'd0);
    in_router4 = 7'b1_000001; tick();
    in_router4 = '0;          tick();
    in_router4 = 7'b1_000010; tick();
    in_router4 = '0;          tick(2);
    chk("t4_drop", {6'd0, led_drop}, 7'd1);
    chk("t4_still_full", hex_count, SEG[8]);
    do_pop();
    tick();
    chk("t4_pop_router", hex_router, SEG[5]);
    chk("t4_pop_data", hex_data, SEG[1]);
    chk("t4_refill", hex_count, SEG[8]);
    for (int k = 2; k <= 8; k++) begin
      do_pop();
      chk($sformatf("t4_r5_data%0d", k), hex_data, SEG[k]);
    end
    do_pop();
    chk("t4_r4_router", hex_router, SEG[4]);
    chk("t4_r4_data", hex_data, SEG[2]);
    chk("t4_drained", hex_count, SEG[0]);

    // key held high pops exactly once
    in_router1 = 7'b1_000001; tick();
    in_router1 = 7'b1_000010; tick();
    in_router1 = 7'b1_000011; tick();
    in_router1 = '0;
    tick(3);
    chk("t5_three", hex_count, SEG[3]);
    key_next = 1'b1;
    tick(20);
    chk("t5_one_pop", hex_count, SEG[2]);
    chk("t5_data1", hex_data, SEG[1]);
    key_next = 1'b0;
    tick();
    do_pop();
    do_pop();
    chk("t5_data3", hex_data, SEG[3]);
    do_pop();
    tick();
    chk("t5_empty_pop_data", hex_data, SEG[3]);
    chk("t5_empty_pop_router", hex_router, SEG[1]);
    chk("t5_empty_led", {6'd0, led_empty}, 7'd1);
    // pop coinciding with first push into an empty FIFO is ignored
    in_router2 = 7'b1_000111;
    tick();
    key_next = 1'b1;
    tick();
    key_next = 1'b0;
    tick(2);
    chk("t5_nofall_data", hex_data, SEG[3]);
    chk("t5_nofall_count", hex_count, SEG[1]);

    // clear with four queued and router1 held valid
    in_router3 = 7'b1_000001; tick();
    in_router3 = 7'b1_000010; tick();
    in_router3 = '0;
    in_router1 = 7'b1_001010;
    tick(4);
    chk("t6_four", hex_count, SEG[4]);
    chk("t6_drop_before", {6'd0, led_drop}, 7'd1);
    sw_clear = 1'b1;
    tick(2);
    chk("t6_count0", hex_count, SEG[0]);
    chk("t6_data_blank", hex_data, BLANK);
    chk("t6_router_blank", hex_router, BLANK);
    chk("t6_drop_clr", {6'd0, led_drop}, 7'd0);
    chk("t6_empty", {6'd0, led_empty}, 7'd1);
    sw_clear = 1'b0;
    in_router4 = 7'b0_001111;
    tick(5);
    chk("t6_no_recapture", hex_count, SEG[0]);
    in_router1 = 7'b1_001011;
    tick(3);
    chk("t6_new_capture", hex_count, SEG[1]);
    do_pop();
    chk("t6_data_b", hex_data, SEG[11]);
    chk("t6_router1", hex_router, SEG[1]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/collect_data_5.md
Name: collect_data_5

Overview:
- Sink stage on the output side of the 5-router NoC; mirror of the injection selector.
- Watches the five router delivery buses and captures each newly delivered packet with its router number.
- Queues captures in a small FIFO; the operator steps through them with a key, and results show on seven-segment displays.
- Gives board-level confirmation of where an injected value ended up.

Parameters:
- N2, 7, packet width; bit N2-1 = valid flag, bits N2-2:0 = payload.
- DEPTH, 8, capture FIFO depth (power of two).
- AW, 3, log2(DEPTH).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- in_router1..in_router5  input  N2 each  delivery bus from routers 1..5; level-held by the router
- key_next  input  1  level; each 0->1 transition pops one FIFO entry to the display
- sw_clear  input  1  level; while high, flushes captured state
- hex_data  output  7  payload[3:0] of displayed entry, hex digit 0-F
- hex_router  output  7  router number 1-5 of displayed entry
- hex_count  output  7  FIFO occupancy 0-8
- led_empty  output  1  FIFO empty
- led_drop  output  1  at least one capture lost since reset/clear

Behaviour:
- Seven-segment encoding:
  - Active-low, segment order abcdefg, i.e. ~pattern; 0 = ~7'b1111110, 1 = ~7'b0110000, etc.
  - A-F use standard glyphs (A, b, C, d, E, F).
  - Blank = 7'b1111111.
- Reset (rst=1 at posedge), all registered:
  - FIFO empty, pending cleared, display invalid, drop counter 0, key flag 0, prev-input registers 0.
  - Outputs: hex_data = hex_router = blank; hex_count = "0"; led_empty = 1; led_drop = 0.
- Capture detection, per router i:
  - prev_i registers in_router_i every cycle.
  - Event_i = in_router_i[N2-1] && (!prev_i[N2-1] || in_router_i != prev_i), i.e. valid rising, or payload change while valid.
  - Invalid input is never captured.
- Pending slots, one per router:
  - Event_i sets pend_i and stores the payload at the next edge.
  - Event_i while pend_i is already set and not granted that cycle: payload overwritten, drop counter +1.
- Drop counter:
  - 4 bits, saturates at 15.
  - led_drop = (count != 0).
- Drain arbiter:
  - Fixed priority, router1 highest.
  - Each cycle, if any pend set and FIFO not full: write {router_no[2:0], payload} and clear that pend.
  - Same-cycle event on the granted router re-sets pend with the new payload; no drop.
  - FIFO full: pend slots hold; no writes.
- FIFO:
  - Occupancy counter 0..DEPTH; write and read pointers wrap modulo DEPTH.
  - Pop = key_next rising edge, detected via a flag register.
  - Pop while empty: ignored; display unchanged; no fall-through of a same-cycle write.
  - Same-cycle push and pop: both occur; occupancy unchanged.
- Display register:
  - Loaded on pop with the head entry; display valid set.
  - Stays until the next pop, clear, or reset.
- Latency:
  - Packet sampled at edge E0 -> pend at E0 -> FIFO entry at E1 -> hex_count/led_empty updated at E2.
  - Pop sampled at edge P0 -> hex_data/hex_router updated at P1.
- sw_clear=1:
  - Same effect as reset on FIFO, pend, display, drop counter, and key flag.
  - prev-input registers keep tracking, so held-valid inputs are not re-captured after clear.
  - Captures are suppressed while high.
- Router number outside 1-5 cannot occur; decoder default is blank.

Test Plan:
- Reset, in_router3 = 7'b1_000101, key_next pulse:
  - hex_count "1" two cycles after input; after pop, hex_router "3", hex_data "5", hex_count "0", led_empty = 1.
- All five routers go valid the same cycle, payloads 1..5:
  - FIFO filled in order router1..router5 on five consecutive cycles.
  - Five pops display (1,1),(2,2),(3,3),(4,4),(5,5).
- Hold in_router2 valid and constant for 100 cycles:
  - Exactly one capture.
  - Then change payload 6->9 while valid: second capture with data "9".
- Fill FIFO to 8 (hex_count "8"), then events on router4 with payloads 1 then 2 (valid dropped between them):
  - led_drop = 1; pend4 holds 2.
  - After one pop, router4/2 enters FIFO; hex_count stays "8".
- key_next held high 20 cycles with 3 entries queued:
  - Exactly one pop; hex_count "2".
  - Pop on empty FIFO leaves display unchanged.
- Assert sw_clear with 4 queued and in_router1 held valid:
  - hex_count "0", displays blank, led_drop = 0.
  - After release, no re-capture of router1 until its payload changes.
